// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared types and constants for the AHB memory slave.
//   - htrans_e : AHB transfer type encoding
//   - hsize_e  : legal transfer sizes (byte / halfword / word)
//   - hresp_e  : slave response encoding
//   - state_e  : slave response FSM states
//   - LP_MAX_WAIT_STATES : upper bound on configurable wait states
//   - byte_enables() : little-endian byte-lane mask for a size/address pair
// ---------------------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  localparam int LP_MAX_WAIT_STATES = 3;

  // Byte lanes touched by a transfer; illegal sizes touch nothing.
  function automatic logic [3:0] byte_enables(input logic [2:0] size,
                                              input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      3'd0:    be = 4'b0001 << lane;
      3'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
      3'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// ---------------------------------------------------------------------------
// ahb_mem_array
// MEM_DEPTH x 32-bit storage with per-byte write enables and a combinational
// read port. Contents are never reset.
// Ports:
//   i_clk    : clock, writes on rising edge
//   i_we     : write strobe
//   i_waddr  : word index for writes
//   i_be     : byte-lane write enables (bit n -> bits 8n+7:8n)
//   i_wdata  : write data
//   i_raddr  : word index for reads
//   o_rdata  : read data (0 for indices beyond MEM_DEPTH)
// ---------------------------------------------------------------------------
module ahb_mem_array #(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [MEM_DEPTH];

  // Byte-masked write port.
  always_ff @(posedge i_clk) begin
    if (i_we && (32'(i_waddr) < 32'(MEM_DEPTH))) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Asynchronous read port, guarded for non-power-of-two depths.
  always_comb begin
    if (32'(i_raddr) < 32'(MEM_DEPTH)) begin
      o_rdata = r_mem[i_raddr];
    end else begin
      o_rdata = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/ahb_mem_slave.sv
// ---------------------------------------------------------------------------
// ahb_mem_slave
// AHB-Lite memory slave with configurable wait states and two-cycle ERROR
// responses for illegal transfers (bad size, misaligned, out of range).
// Ports:
//   hclk      : clock
//   hreset    : synchronous active-high reset
//   hsel      : slave select
//   haddr     : byte address (address phase)
//   htrans    : transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hwrite    : 1 = write
//   hsize     : 0 byte, 1 halfword, 2 word
//   hburst    : burst type (ignored)
//   hwdata    : write data (data phase)
//   hready    : bus ready from interconnect
//   hreadyout : slave ready (registered)
//   hresp     : 0 OKAY, 1 ERROR (registered)
//   hrdata    : read data, non-zero only in a completing read cycle
// ---------------------------------------------------------------------------
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int LP_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LP_WS = (WAIT_STATES > LP_MAX_WAIT_STATES) ? LP_MAX_WAIT_STATES :
                         ((WAIT_STATES < 0) ? 0 : WAIT_STATES);
  localparam logic [32:0] LP_MEM_BYTES = 33'(MEM_DEPTH) * 33'd4;

  state_e             r_state;
  logic [1:0]         r_cnt;
  logic               r_hreadyout;
  hresp_e             r_hresp;
  logic [31:0]        r_hrdata;
  logic [LP_AW+1:0]   r_addr;
  logic               r_write;
  logic [2:0]         r_size;
  logic               r_dp_valid;

  logic               w_accept;
  logic               w_illegal;
  logic               w_done;
  logic               w_commit;
  logic               w_same_word;
  logic [3:0]         w_be;
  logic [LP_AW-1:0]   w_raddr;
  logic [31:0]        w_mem_rdata;
  logic [31:0]        w_fwd_rdata;
  logic               w_unused;

  assign w_unused = ^hburst;

  // The slave's own hreadyout also gates acceptance so a stalled data phase
  // can never be overlapped by a new address phase.
  assign w_accept = hsel && hready && r_hreadyout &&
                    ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  assign w_illegal = (hsize > HSIZE_WORD) ||
                     ((hsize == HSIZE_HALF) && haddr[0]) ||
                     ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00)) ||
                     ({1'b0, haddr} >= LP_MEM_BYTES);

  // A pending data phase finishes on any edge where the slave shows ready.
  assign w_done      = r_dp_valid && r_hreadyout;
  assign w_commit    = w_done && r_write && !hreset;
  assign w_be        = byte_enables(r_size, r_addr[1:0]);
  assign w_same_word = (r_addr[LP_AW+1:2] == haddr[LP_AW+1:2]);

  // While stalled the read port serves the registered address; otherwise it
  // looks ahead at the incoming address for zero-wait reads.
  assign w_raddr = (r_state == ST_WAIT) ? r_addr[LP_AW+1:2] : haddr[LP_AW+1:2];

  // Bypass a write committing on this same edge into a zero-wait read.
  always_comb begin
    w_fwd_rdata = w_mem_rdata;
    for (int b = 0; b < 4; b++) begin
      if (w_commit && w_same_word && w_be[b]) begin
        w_fwd_rdata[8*b +: 8] = hwdata[8*b +: 8];
      end else begin
        w_fwd_rdata[8*b +: 8] = w_mem_rdata[8*b +: 8];
      end
    end
  end

  // Response FSM with registered bus outputs and address-phase capture.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 2'd0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_hrdata    <= 32'h0000_0000;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_size      <= 3'd0;
      r_dp_valid  <= 1'b0;
    end else begin
      r_hrdata <= 32'h0000_0000;
      if (w_done) begin
        r_dp_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE, ST_ERR2: begin
          r_state     <= ST_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
          if (w_accept) begin
            r_addr  <= haddr[LP_AW+1:0];
            r_write <= hwrite;
            r_size  <= hsize;
            if (w_illegal) begin
              r_state     <= ST_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_ERROR;
            end else begin
              r_dp_valid <= 1'b1;
              if (LP_WS == 0) begin
                if (!hwrite) begin
                  r_hrdata <= w_fwd_rdata;
                end
              end else begin
                r_state     <= ST_WAIT;
                r_cnt       <= 2'(LP_WS);
                r_hreadyout <= 1'b0;
              end
            end
          end
        end
        ST_WAIT: begin
          r_hresp <= HRESP_OKAY;
          if (r_cnt == 2'd1) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 2'd0;
            r_hreadyout <= 1'b1;
            if (!r_write) begin
              r_hrdata <= w_mem_rdata;
            end
          end else begin
            r_cnt       <= r_cnt - 2'd1;
            r_hreadyout <= 1'b0;
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= 2'd0;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
          r_dp_valid  <= 1'b0;
        end
      endcase
    end
  end

  ahb_mem_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (LP_AW)
  ) u_mem (
    .i_clk   (hclk),
    .i_we    (w_commit),
    .i_waddr (r_addr[LP_AW+1:2]),
    .i_be    (w_be),
    .i_wdata (hwdata),
    .i_raddr (w_raddr),
    .o_rdata (w_mem_rdata)
  );

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign hrdata    = r_hrdata;

endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 SHALL provide parameter MEM_DEPTH, default 256, meaning 32-bit words of storage (byte address range 0 to MEM_DEPTH*4-1).
REQ-002 SHALL provide parameter WAIT_STATES, default 1, range 0..3, meaning extra data-phase cycles per OKAY transfer.
REQ-003 SHALL have one clock and a synchronous active-high reset, ports as follows:
- hclk  input  1  clock, all state changes on rising edge
- hreset  input  1  synchronous active-high reset
- hsel  input  1  slave select
- haddr  input  32  byte address
- htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  input  1  1=write, 0=read
- hsize  input  3  0=byte, 1=halfword, 2=word, others illegal
- hburst  input  3  burst type, accepted but functionally ignored
- hwdata  input  32  write data, valid in data phase
- hready  input  1  bus-level ready from interconnect
- hreadyout  output  1  slave ready
- hresp  output  1  0=OKAY, 1=ERROR
- hrdata  output  32  read data

Function
REQ-004 An address phase SHALL be accepted only when hsel=1, hready=1 and htrans is NONSEQ or SEQ; haddr, hwrite and hsize SHALL be registered at that edge.
REQ-005 IDLE or BUSY with hsel=1 and hready=1, or hsel=0, SHALL produce a zero-wait OKAY response (hreadyout=1, hresp=0) in the following cycle.
REQ-006 FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE: on accepted legal transfer with WAIT_STATES=0, stay IDLE and complete next cycle; with WAIT_STATES>0, go to WAIT with counter=WAIT_STATES.
- WAIT: hreadyout=0, counter decrements each cycle; at counter=1, return to IDLE, hreadyout=1 next cycle (data phase completes).
- On accepted illegal transfer: go to ERR1.
- ERR1: hreadyout=0, hresp=1; always go to ERR2.
- ERR2: hreadyout=1, hresp=1; return to IDLE, or to ERR1/WAIT if a new transfer is accepted in this cycle.
REQ-007 Legal transfer latency SHALL be exactly 1+WAIT_STATES cycles from address-phase edge to completion edge.
REQ-008 A transfer SHALL be illegal (two-cycle ERROR, no memory access) if hsize>2, if it is misaligned (halfword with haddr[0]=1, word with haddr[1:0]!=0), or if haddr>=MEM_DEPTH*4.
REQ-009 Writes SHALL commit at the completion edge of the data phase using hwdata sampled at that edge; byte lanes little-endian: byte lane = haddr[1:0], halfword lanes = haddr[1]*2 +{0,1}; other bytes unchanged.
REQ-010 Reads SHALL drive the full addressed word on hrdata during the completing data-phase cycle; hrdata SHALL be 0 in all other cycles.
REQ-011 A read immediately following a write to the same word SHALL return the newly written data with no extra wait.
REQ-012 New address phases SHALL NOT be accepted while hreadyout=0 (hready=0 on bus); address inputs in those cycles are ignored.
REQ-013 hburst SHALL NOT alter behaviour; SEQ beats are treated identically to NONSEQ, including the per-beat wait states.

Reset
REQ-014 While hreset=1 at a rising edge: state=IDLE, counter=0, hreadyout=1, hresp=0, hrdata=0, registered address-phase signals cleared.
REQ-015 Reset asserted mid-transfer SHALL abort it; a pending write SHALL NOT commit.
REQ-016 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-017 Shared package ahb_pkg SHALL hold htrans, hsize and hresp typedef enums, the FSM state typedef, and the max WAIT_STATES constant.
REQ-018 Storage SHALL be a sub-module ahb_mem_array (MEM_DEPTH x 32, 4-bit byte-write-enable, combinational read port).

Verification
REQ-019 WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> OKAY, no hreadyout low, hrdata=0xDEADBEEF.
REQ-020 WAIT_STATES=2: read 0x20 -> hreadyout low exactly 2 cycles, data valid on third cycle after address phase.
REQ-021 Write word 0x11223344 to 0x30, then write byte 0xAA to 0x32, then read 0x30 -> 0x11AA3344.
REQ-022 Word read at 0x401 (misaligned) and at 0x400 with MEM_DEPTH=256 (out of range) -> each gives ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1), memory unchanged.
REQ-023 WAIT_STATES=3: start write 0x55 to 0x40, assert hreset during second wait cycle -> outputs at reset values next cycle, subsequent read of 0x40 returns prior contents.
REQ-024 IDLE/BUSY transfers and hsel=0 cycles interleaved with a 4-beat INCR SEQ burst at 0x0 -> zero-wait OKAY for idle cycles, burst data correct per beat.
